div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage sequencer sitting directly upstream of the iterative divider (div_yw).
- Accepts one DIV/DIVU/REM/REMU request from the execute stage and latches its operands and destination register.
- Holds the divider's valid high until the divider reports ready, then issues a one-cycle register-file write-back.
- Stalls the pipeline for the whole operation and supports flush abort and a watchdog timeout.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 63, max edges in BUSY before abort; must exceed the divider's worst case (34).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous reset, active-high
- start_i  input  1  request from EX; sampled only in IDLE
- op_i  input  3  funct3: INST_DIV=100, INST_DIVU=101, INST_REM=110, INST_REMU=111
- dividend_i  input  WIDTH  rs1 value
- divisor_i  input  WIDTH  rs2 value
- rd_addr_i  input  5  destination register
- flush_i  input  1  pipeline flush (jump/trap)
- div_valid_o  output  1  to divider valid_i
- div_dividend_o  output  WIDTH  latched dividend
- div_divisor_o  output  WIDTH  latched divisor
- div_op_o  output  3  latched op
- div_data_i  input  WIDTH  divider data_o
- div_ready_i  input  1  divider ready_o
- busy_o  output  1  stall request to pipeline
- wb_we_o  output  1  register write enable (1-cycle pulse)
- wb_addr_o  output  5  write address
- wb_data_o  output  WIDTH  write data
- err_o  output  1  timeout pulse

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs and latched registers 0.
- All outputs are registered; busy_o = (state != IDLE).
- States and transitions:
  - IDLE: if start_i & op_i[2] & ~flush_i, latch op, operands and rd, set div_valid_o=1 and timeout counter=0, go BUSY. start_i with op_i[2]=0 is ignored.
  - BUSY: div_valid_o held 1; counter increments every edge.
    - flush_i=1: div_valid_o<=0, go IDLE, no write-back. flush_i takes priority over div_ready_i on the same edge.
    - else div_ready_i=1: capture div_data_i into wb_data_o, set wb_we_o=1, wb_addr_o=rd, div_valid_o<=0, go WB.
    - else counter==TIMEOUT_CYCLES: div_valid_o<=0, err_o=1 for one cycle, go IDLE, no write-back.
  - WB: wb_we_o=1 for exactly this one cycle; flush_i ignored; next edge go IDLE with wb_we_o<=0.
- div_valid_o is low for at least one edge between consecutive requests, so the divider returns to its idle state; WB and IDLE together guarantee this.
- Latched operands and op stay stable for the whole of BUSY.
- Latency with the team divider:
  - Normal operation: wb_we_o rises 35 edges after the edge that samples start_i.
  - Divide-by-zero and overflow (0x80000000 / 0xFFFFFFFF): 3 edges.
- Result values are fully determined by the divider; this block performs no arithmetic on them.
- Reset mid-operation: immediate return to IDLE, div_valid_o=0, no write-back.

Optional Feature:
- Macro: DIV_RESULT_CACHE_EN.
- Defined: a single-entry cache holds {op, dividend, divisor, result, valid bit}, updated on every write-back.
  - In IDLE, a start_i whose op and operands exactly match a valid entry goes straight to WB. wb_data_o = cached result, div_valid_o stays 0, write-back one edge after the start edge.
  - Reset clears the valid bit. Flush and timeout do not update the entry.
- Undefined: no cache logic; every request goes through BUSY.

Test Plan:
- DIVU 100/7, rd=5 -> wb_we_o pulse 35 edges after start, wb_addr_o=5, wb_data_o=14, busy_o high throughout.
- DIV 0xFFFFFFF9 (-7) / 2, then REM with the same operands -> first write-back 0xFFFFFFFD, second write-back 0xFFFFFFFF. div_valid_o is low for at least one edge between the two requests.
- DIVU 5/0 -> write-back 0xFFFFFFFF, 3 edges after start. REMU 5/0 -> write-back 5.
- DIV 100/7 with flush_i pulsed 10 edges after start -> div_valid_o drops, no wb_we_o, busy_o low on the next edge; a following DIVU 9/3 writes back 3.
- Divider model holds div_ready_i=0 -> err_o pulses exactly at counter=63, no write-back, state IDLE.
- With DIV_RESULT_CACHE_EN defined: DIVU 100/7 issued twice -> second write-back is 14, one edge after its start, and div_valid_o stays 0.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Handshake/bus bundle between the EX stage, div_issue_ctrl and the iterative divider.
// The controller uses the slave modport; the surrounding pipeline/divider side uses master.
interface div_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic [4:0]       rd_addr_i;
  logic             flush_i;
  logic             div_valid_o;
  logic [WIDTH-1:0] div_dividend_o;
  logic [WIDTH-1:0] div_divisor_o;
  logic [2:0]       div_op_o;
  logic [WIDTH-1:0] div_data_i;
  logic             div_ready_i;
  logic             busy_o;
  logic             wb_we_o;
  logic [4:0]       wb_addr_o;
  logic [WIDTH-1:0] wb_data_o;
  logic             err_o;

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  div_data_i, div_ready_i,
    output div_valid_o, div_dividend_o, div_divisor_o, div_op_o,
    output busy_o, wb_we_o, wb_addr_o, wb_data_o, err_o
  );

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output div_data_i, div_ready_i,
    input  div_valid_o, div_dividend_o, div_divisor_o, div_op_o,
    input  busy_o, wb_we_o, wb_addr_o, wb_data_o, err_o
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer in front of the iterative divider: latch, hold valid, write back, stall.
// Optional single-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 63
) (
  input logic             clk_i,
  input logic             rst_i,
  div_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             err_q, err_d;
  logic             accept;
  logic             hit;

  assign accept = bus.start_i & bus.op_i[2] & ~bus.flush_i;

`ifdef DIV_RESULT_CACHE_EN
  logic             c_valid_q;
  logic [2:0]       c_op_q;
  logic [WIDTH-1:0] c_a_q, c_b_q, c_res_q;

  assign hit = c_valid_q && (c_op_q == bus.op_i) &&
               (c_a_q == bus.dividend_i) && (c_b_q == bus.divisor_i);

  // Only results actually produced by the divider refill the entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_valid_q <= 1'b0;
      c_op_q    <= '0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_res_q   <= '0;
    end else if (state_q == S_BUSY && !bus.flush_i && bus.div_ready_i) begin
      c_valid_q <= 1'b1;
      c_op_q    <= op_q;
      c_a_q     <= dividend_q;
      c_b_q     <= divisor_q;
      c_res_q   <= bus.div_data_i;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    op_d       = op_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = bus.op_i;
          dividend_d = bus.dividend_i;
          divisor_d  = bus.divisor_i;
          rd_d       = bus.rd_addr_i;
          cnt_d      = '0;
          if (hit) begin
`ifdef DIV_RESULT_CACHE_EN
            wb_data_d = c_res_q;
`endif
            we_d      = 1'b1;
            wb_addr_d = bus.rd_addr_i;
            state_d   = S_WB;
          end else begin
            valid_d = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.flush_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (bus.div_ready_i) begin
          wb_data_d = bus.div_data_i;
          we_d      = 1'b1;
          wb_addr_d = rd_q;
          valid_d   = 1'b0;
          state_d   = S_WB;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.div_valid_o    = valid_q;
  assign bus.div_dividend_o = dividend_q;
  assign bus.div_divisor_o  = divisor_q;
  assign bus.div_op_o       = op_q;
  assign bus.busy_o         = (state_q != S_IDLE);
  assign bus.wb_we_o        = we_q;
  assign bus.wb_addr_o      = wb_addr_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider (34-edge normal, 2-edge fast path).
module tb_div_issue_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.WIDTH(W)) bus ();

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(63)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Divider stand-in: RISC-V M-extension results; ready registered after N valid edges.
  function automatic logic [31:0] div_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op[1:0])
      2'b00:   div_ref = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      2'b01:   div_ref = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   div_ref = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: div_ref = (b == 0) ? a : a % b;
    endcase
  endfunction

  int   m_cnt;
  logic m_ready;
  logic [31:0] m_data;
  int   m_need;

  always_comb begin
    m_need = 34;
    if (bus.div_divisor_o == 0 ||
        (!bus.div_op_o[0] && bus.div_dividend_o == 32'h8000_0000 && bus.div_divisor_o == 32'hFFFF_FFFF))
      m_need = 2;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_ready <= 1'b0; m_data <= '0;
    end else if (!bus.div_valid_o) begin
      m_cnt <= 0; m_ready <= 1'b0;
    end else if (!m_ready && !hold) begin
      if (m_cnt + 1 >= m_need) begin
        m_ready <= 1'b1;
        m_data  <= div_ref(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);
      end
      m_cnt <= m_cnt + 1;
    end
  end

  assign bus.div_ready_i = m_ready;
  assign bus.div_data_i  = m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b; bus.rd_addr_i = rd;
  endtask

  // lat: edges from the start edge to the edge that raises wb_we_o (0 = raised by the start edge).
  task automatic run_vec(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok, valid_ok;
    logic [4:0]  got_addr;
    logic [31:0] got_data;
    drive(op, a, b, rd);
    @(posedge clk); #1;
    lat = -1; got_addr = '0; got_data = '0;
    busy_ok  = bus.busy_o;
    valid_ok = (exp_lat == 0) ? !bus.div_valid_o : bus.div_valid_o;
    if (bus.wb_we_o) begin lat = 0; got_addr = bus.wb_addr_o; got_data = bus.wb_data_o; end
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.wb_we_o) begin
        lat = k; got_addr = bus.wb_addr_o; got_data = bus.wb_data_o;
      end else begin
        busy_ok  &= bus.busy_o;
        valid_ok &= bus.div_valid_o;
      end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_wb_addr"}, {27'd0, got_addr}, {27'd0, rd});
    chk({nm, "_wb_data"}, got_data, exp);
    chk({nm, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, "_valid_level"}, {31'd0, valid_ok}, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_after_wb"}, {29'd0, bus.wb_we_o, bus.div_valid_o, bus.busy_o}, 32'd0);
  endtask

  task automatic watch_no_wb(input string nm, input int edges);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < edges; k++) begin
      @(posedge clk); #1;
      seen |= bus.wb_we_o;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int errk;
    logic we_bad;

    vecs[0] = '{3'b101, 32'd100,         32'd7,           5'd5,  32'd14,          35};
    vecs[1] = '{3'b100, 32'hFFFF_FFF9,   32'd2,           5'd6,  32'hFFFF_FFFD,   35};
    vecs[2] = '{3'b110, 32'hFFFF_FFF9,   32'd2,           5'd7,  32'hFFFF_FFFF,   35};
    vecs[3] = '{3'b101, 32'd5,           32'd0,           5'd8,  32'hFFFF_FFFF,   3};
    vecs[4] = '{3'b111, 32'd5,           32'd0,           5'd9,  32'd5,           3};
    vecs[5] = '{3'b100, 32'h8000_0000,   32'hFFFF_FFFF,   5'd10, 32'h8000_0000,   3};
    vecs[6] = '{3'b110, 32'h8000_0000,   32'hFFFF_FFFF,   5'd11, 32'd0,           3};
    vecs[7] = '{3'b100, 32'd100,         32'd0,           5'd12, 32'hFFFF_FFFF,   3};
    vecs[8] = '{3'b110, 32'hFFFF_FFF9,   32'd0,           5'd13, 32'hFFFF_FFF9,   3};

    rst = 1'b1; hold = 1'b0;
    bus.start_i = 1'b0; bus.op_i = '0; bus.dividend_i = '0; bus.divisor_i = '0;
    bus.rd_addr_i = '0; bus.flush_i = 1'b0;
    #12;
    chk("reset_ctrl", {27'd0, bus.div_valid_o, bus.busy_o, bus.wb_we_o, bus.err_o, 1'b0}, 32'd0);
    chk("reset_latched", bus.div_dividend_o | bus.div_divisor_o | {29'd0, bus.div_op_o}, 32'd0);
    chk("reset_wb", bus.wb_data_o | {27'd0, bus.wb_addr_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Non-divide funct3 and a flushed start must both be ignored.
    drive(3'b000, 32'd100, 32'd7, 5'd1);
    @(posedge clk); #1;
    chk("ignore_op2_low", {30'd0, bus.busy_o, bus.div_valid_o}, 32'd0);
    @(negedge clk);
    bus.op_i = 3'b101; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    chk("ignore_start_flush", {30'd0, bus.busy_o, bus.div_valid_o}, 32'd0);
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;

    // Flush sampled on the 10th edge after start.
    drive(3'b100, 32'd100, 32'd7, 5'd14);
    @(posedge clk);
    @(negedge clk); bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.flush_i = 1'b1;
    @(posedge clk); #1;
    chk("flush_abort", {29'd0, bus.busy_o, bus.div_valid_o, bus.wb_we_o}, 32'd0);
    @(negedge clk); bus.flush_i = 1'b0;
    watch_no_wb("flush_no_wb", 40);
    run_vec("after_flush", 3'b101, 32'd9, 32'd3, 5'd15, 32'd3, 35);

    // Divider never answers: abort on the edge that sees counter==63.
    @(negedge clk); hold = 1'b1;
    drive(3'b101, 32'd100, 32'd7, 5'd16);
    @(posedge clk);
    @(negedge clk); bus.start_i = 1'b0;
    errk = -1; we_bad = 1'b0;
    for (int k = 1; k <= 100 && errk < 0; k++) begin
      @(posedge clk); #1;
      we_bad |= bus.wb_we_o;
      if (bus.err_o) errk = k;
    end
    chk("timeout_edge", errk, 64);
    chk("timeout_state", {30'd0, bus.busy_o, bus.div_valid_o}, 32'd0);
    chk("timeout_no_wb", {31'd0, we_bad}, 32'd0);
    @(posedge clk); #1;
    chk("timeout_err_pulse", {31'd0, bus.err_o}, 32'd0);
    @(negedge clk); hold = 1'b0;

    // Asynchronous reset in the middle of an operation.
    drive(3'b101, 32'd100, 32'd7, 5'd17);
    @(posedge clk);
    @(negedge clk); bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midop_reset", {29'd0, bus.busy_o, bus.div_valid_o, bus.wb_we_o}, 32'd0);
    chk("midop_reset_latch", bus.div_dividend_o, 32'd0);
    @(negedge clk); rst = 1'b0;
    watch_no_wb("midop_reset_no_wb", 40);

`ifdef DIV_RESULT_CACHE_EN
    run_vec("cache_fill", 3'b101, 32'd100, 32'd7, 5'd18, 32'd14, 35);
    run_vec("cache_hit", 3'b101, 32'd100, 32'd7, 5'd19, 32'd14, 0);
    run_vec("cache_miss_op", 3'b111, 32'd100, 32'd7, 5'd20, 32'd2, 35);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
